// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
    localparam logic [1:0] ALIGN_BITS = 2'b00;

    typedef enum logic {
        IDLE,
        WAIT
    } fetchState_e;

    function automatic logic [WORD_W-1:0] alignWord(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], ALIGN_BITS};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Issuer handshake, instruction-memory bus and branch redirect of the fetch stage.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic              readyOut;
    logic [WORD_W-1:0] dataOut;
    logic              triggerIn;
    logic              imemReq;
    logic [WORD_W-1:0] imemAddr;
    logic              imemValid;
    logic [WORD_W-1:0] imemData;
    logic              branchValid;
    logic [WORD_W-1:0] branchAddr;

    modport master (
        output readyOut, dataOut, imemReq, imemAddr,
        input  triggerIn, imemValid, imemData, branchValid, branchAddr
    );

    modport slave (
        input  readyOut, dataOut, imemReq, imemAddr,
        output triggerIn, imemValid, imemData, branchValid, branchAddr
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch buffer of up to two words held as head and tail registers.
module fetch_queue import fetch_pkg::*; #(
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] head_o,
    output logic [1:0]        count_o
);

    localparam logic [1:0] FULL = 2'(QDEPTH);

    logic [WORD_W-1:0] head_q;
    logic [WORD_W-1:0] tail_q;
    logic [1:0]        count_q;

    // A pop shifts the tail forward; a simultaneous pop and push keeps occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q != FULL) begin
                        if (count_q == 2'd0) begin
                            head_q <= data_i;
                        end else begin
                            tail_q <= data_i;
                        end
                        count_q <= count_q + 2'd1;
                    end
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end else begin
                        head_q <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request FSM, two-phase ack detection, redirect.
// Define FETCH_TRIG_SYNC_EN to pass triggerIn through a 2-flop synchroniser.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam logic [1:0] QDEPTH_C = 2'(QDEPTH);

    logic trigS;

`ifdef FETCH_TRIG_SYNC_EN
    logic trigMeta_q;
    logic trigSync_q;

    // Left out of reset so the synchronised level is already valid when reset releases.
    always_ff @(posedge clk) begin
        trigMeta_q <= bus.triggerIn;
        trigSync_q <= trigMeta_q;
    end

    assign trigS = trigSync_q;
`else
    assign trigS = bus.triggerIn;
`endif

    fetchState_e       state_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] imemAddr_q;
    logic              imemReq_q;
    logic              drop_q;
    logic              blank_q;
    logic              trigSeen_q;
    logic              ackErr_q;

    logic [1:0]        queueCount;
    logic [WORD_W-1:0] queueHead;
    logic              readyOut;
    logic              ack;
    logic              pop_d;
    logic              push_d;
    logic              canIssue_d;
    logic [WORD_W-1:0] pcInc_d;

    assign readyOut   = (queueCount != 2'd0) && !blank_q;
    assign ack        = trigS != trigSeen_q;
    assign pop_d      = ack && readyOut;
    assign push_d     = (state_q == WAIT) && bus.imemValid && !drop_q && !bus.branchValid;
    assign canIssue_d = (state_q == IDLE) && (queueCount < QDEPTH_C) && !bus.branchValid;
    assign pcInc_d    = pc_q + PC_STEP;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_d),
        .pop_i   (pop_d),
        .flush_i (bus.branchValid),
        .data_i  (bus.imemData),
        .head_o  (queueHead),
        .count_o (queueCount)
    );

    // A branch that catches a request in flight marks its eventual response for discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= alignWord(RESET_PC);
            imemAddr_q <= alignWord(RESET_PC);
            imemReq_q  <= 1'b0;
            drop_q     <= 1'b0;
            blank_q    <= 1'b0;
            trigSeen_q <= trigS;
            ackErr_q   <= 1'b0;
        end else begin
            trigSeen_q <= trigS;
            blank_q    <= pop_d;
            imemReq_q  <= 1'b0;
            ackErr_q   <= ackErr_q | (ack && !readyOut);
            if (bus.branchValid) begin
                pc_q <= alignWord(bus.branchAddr);
            end
            unique case (state_q)
                IDLE: begin
                    if (canIssue_d) begin
                        state_q    <= WAIT;
                        imemReq_q  <= 1'b1;
                        imemAddr_q <= pc_q;
                    end
                end
                WAIT: begin
                    if (bus.imemValid) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        if (!drop_q && !bus.branchValid) begin
                            pc_q <= pcInc_d;
                        end
                    end else if (bus.branchValid) begin
                        drop_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.readyOut = readyOut;
    assign bus.dataOut  = queueHead;
    assign bus.imemReq  = imemReq_q;
    assign bus.imemAddr = imemAddr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, ack, prefetch limit, redirect, ack+redirect, reset, PC wrap.
module tb_fetch_unit;

`ifdef FETCH_TRIG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk;
    logic rst;

    int compared;
    int mismatched;
    int reqCount;
    logic [31:0] lastReqAddr;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .QDEPTH   (2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'hE3A0_1005;
            32'h0000_0004: return 32'hE3A0_2006;
            default:       return {addr[15:0] ^ 16'hC0DE, addr[15:0]};
        endcase
    endfunction

    // One-cycle-latency memory for the main unit; also logs every request it sees.
    initial begin
        logic        pend;
        logic [31:0] pendAddr;
        pend = 1'b0;
        pendAddr = '0;
        reqCount = 0;
        lastReqAddr = '0;
        bus.imemValid = 1'b0;
        bus.imemData = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.imemValid = pend;
            bus.imemData = pend ? memWord(pendAddr) : 32'h0;
            pend = bus.imemReq;
            pendAddr = bus.imemAddr;
            if (bus.imemReq) begin
                reqCount = reqCount + 1;
                lastReqAddr = bus.imemAddr;
            end
        end
    end

    initial begin
        logic        pend;
        logic [31:0] pendAddr;
        pend = 1'b0;
        pendAddr = '0;
        bus2.imemValid = 1'b0;
        bus2.imemData = '0;
        forever begin
            @(posedge clk);
            #2;
            bus2.imemValid = pend;
            bus2.imemData = pend ? memWord(pendAddr) : 32'h0;
            pend = bus2.imemReq;
            pendAddr = bus2.imemAddr;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared = compared + 1;
        if (observed !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Takes effect at the next sampled edge; returns at the negedge after it.
    task automatic applyStimulus(input logic doToggle, input logic doBranch, input logic [31:0] target);
        if (doToggle) begin
            bus.triggerIn = ~bus.triggerIn;
            repeat (SYNC_LAT) @(negedge clk);
        end
        bus.branchValid = doBranch;
        bus.branchAddr = target;
        @(negedge clk);
        bus.branchValid = 1'b0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.triggerIn = 1'b0;
        bus.branchValid = 1'b0;
        bus.branchAddr = '0;
        bus2.triggerIn = 1'b0;
        bus2.branchValid = 1'b0;
        bus2.branchAddr = '0;

        stepCycles(3);
        checkOutput("rst_ready", 32'(bus.readyOut), 32'd0);
        checkOutput("rst_data", bus.dataOut, 32'h0);
        checkOutput("rst_req", 32'(bus.imemReq), 32'd0);
        checkOutput("rst_addr", bus.imemAddr, 32'h0);
        checkOutput("rst_ackerr", 32'(dut.ackErr_q), 32'd0);
        checkOutput("rst_addr2", bus2.imemAddr, 32'hFFFF_FFFC);

        rst = 1'b0;
        bus2.triggerIn = 1'b1;
        stepCycles(1);
        checkOutput("first_req", 32'(bus.imemReq), 32'd1);
        checkOutput("first_addr", bus.imemAddr, 32'h0);
        checkOutput("first_addr2", bus2.imemAddr, 32'hFFFF_FFFC);

        stepCycles(1);
        checkOutput("pre_ready", 32'(bus.readyOut), 32'd0);
        stepCycles(1);
        checkOutput("word0_ready", 32'(bus.readyOut), 32'd1);
        checkOutput("word0_data", bus.dataOut, 32'hE3A0_1005);
        stepCycles(1);
        checkOutput("req4", 32'(bus.imemReq), 32'd1);
        checkOutput("req4_addr", bus.imemAddr, 32'h4);
        checkOutput("wrap_req", 32'(bus2.imemReq), 32'd1);
        checkOutput("wrap_addr", bus2.imemAddr, 32'h0);

        stepCycles(5);
        checkOutput("full_reqcount", 32'(reqCount), 32'd2);
        checkOutput("full_lastaddr", lastReqAddr, 32'h4);
        checkOutput("full_count", 32'(dut.queueCount), 32'd2);
        checkOutput("full_ready", 32'(bus.readyOut), 32'd1);
        checkOutput("full_data", bus.dataOut, 32'hE3A0_1005);
        checkOutput("spurious_ackerr", 32'(dut2.ackErr_q), 32'd1);

        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("ack_blank", 32'(bus.readyOut), 32'd0);
        checkOutput("ack_noreq", 32'(bus.imemReq), 32'd0);
        stepCycles(1);
        checkOutput("word1_ready", 32'(bus.readyOut), 32'd1);
        checkOutput("word1_data", bus.dataOut, 32'hE3A0_2006);
        checkOutput("req8", 32'(bus.imemReq), 32'd1);
        checkOutput("req8_addr", bus.imemAddr, 32'h8);

        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        checkOutput("br_flush", 32'(bus.readyOut), 32'd0);
        stepCycles(1);
        checkOutput("br_dropped", 32'(bus.readyOut), 32'd0);
        checkOutput("br_noreq", 32'(bus.imemReq), 32'd0);
        stepCycles(1);
        checkOutput("br_req", 32'(bus.imemReq), 32'd1);
        checkOutput("br_addr", bus.imemAddr, 32'h100);
        stepCycles(2);
        checkOutput("br_ready", 32'(bus.readyOut), 32'd1);
        checkOutput("br_data", bus.dataOut, 32'hC1DE_0100);

        stepCycles(6);
        checkOutput("refill_count", 32'(dut.queueCount), 32'd2);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        checkOutput("ackbr_ready", 32'(bus.readyOut), 32'd0);
        checkOutput("ackbr_count", 32'(dut.queueCount), 32'd0);
        checkOutput("ackbr_ackerr", 32'(dut.ackErr_q), 32'd0);
        checkOutput("ackbr_noreq", 32'(bus.imemReq), 32'd0);
        stepCycles(1);
        checkOutput("ackbr_req", 32'(bus.imemReq), 32'd1);
        checkOutput("ackbr_addr", bus.imemAddr, 32'h200);
        stepCycles(2);
        checkOutput("ackbr_data", bus.dataOut, 32'hC2DE_0200);
        stepCycles(1);
        checkOutput("pre_rst_addr", bus.imemAddr, 32'h204);

        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("midrst_ready", 32'(bus.readyOut), 32'd0);
        checkOutput("midrst_data", bus.dataOut, 32'h0);
        checkOutput("midrst_req", 32'(bus.imemReq), 32'd0);
        stepCycles(1);
        checkOutput("restart_req", 32'(bus.imemReq), 32'd1);
        checkOutput("restart_addr", bus.imemAddr, 32'h0);
        stepCycles(2);
        checkOutput("restart_ready", 32'(bus.readyOut), 32'd1);
        checkOutput("restart_data", bus.dataOut, 32'hE3A0_1005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
